sme_result_wb: RTL and testbench
================================

// Module: sme_result_wb
// PURPOSE
//  Host-side receiver for SME results (sme_result_t), the return end of the
//  SME instruction/result interface. Buffers results in a small FIFO and
//  presents them to the host GPR writeback port. Keeps a scoreboard of share
//  registers with an outstanding SME result, so host issue stalls on RAW/WAW.
// PARAMETERS
//  DEPTH  4  result FIFO entries; power of 2, >=2
//  XLEN   sme_pkg::XLEN (32)  data width; not overridable
// PORTS
//  g_clk          in   1     clock, rising edge
//  g_reset        in   1     asynchronous, active-high reset
//  flush          in   1     drop all buffered results, clear scoreboard
//  issue_valid    in   1     host issues an sme_instr_t to SME this cycle
//  issue_rs1_addr in   4     share index of rs1 of issuing instr
//  issue_rs2_addr in   4     share index of rs2
//  issue_rd_addr  in   4     share index of rd
//  issue_hazard   out  1     comb: issuing instr touches a pending reg; host must hold
//  res_valid      in   1     SME result valid
//  res_ready      out  1     receiver can accept result
//  res_data       in   $bits(sme_result_t)  {rd_wdata, rd_addr}
//  wb_valid       out  1     writeback valid (FIFO head)
//  wb_ready       in   1     host GPR port accepts writeback
//  wb_rd_addr     out  4     writeback share index
//  wb_rd_wdata    out  XLEN  writeback data
//  pending        out  16    scoreboard, bit i = share i awaiting result
//  proto_err      out  1     1-cycle pulse: result arrived for non-pending rd
// BEHAVIOUR
//  - Reset (async, any time): FIFO empty, pointers 0, pending=0, wb_valid=0,
//    res_ready=1, proto_err=0, wb_rd_addr/wb_rd_wdata=0. Mid-transfer results dropped.
//  - Handshakes: push when res_valid&&res_ready; pop when wb_valid&&wb_ready.
//    wb_valid, once high, holds with stable data until popped or flushed.
//  - FIFO: rd/wr pointers clog2(DEPTH)+1 bits; full = MSBs differ, low bits
//    equal; empty = pointers equal. Pointers wrap modulo 2*DEPTH.
//    res_ready = !full (registered-state only; no push-through-when-full).
//    Simultaneous push+pop when not full/empty: count unchanged, both happen.
//  - Latency: push cycle N -> wb_valid cycle N+1 (FIFO was empty).
//  - Scoreboard: issue accepted = issue_valid && !issue_hazard; sets
//    pending[issue_rd_addr] next edge. Pop clears pending[wb_rd_addr].
//    Same bit set and cleared in one cycle: set wins (new owner).
//    issue_hazard = pending[rs1] | pending[rs2] | pending[rd] (comb).
//    issue_valid while hazard: ignored, no state change.
//  - proto_err: pulses on push of a result whose pending[rd_addr]=0; result
//    is still buffered and written back.
//  - flush: highest priority; next edge FIFO empty, pending=0; push, pop and
//    issue in the flush cycle are discarded. wb_valid low the cycle after.
// CONFIGURATION
//  SME_RESULT_BYPASS_EN defined: when FIFO empty and res_valid, result drives
//    wb_* combinationally (wb_valid=res_valid); if wb_ready the result is not
//    stored and pending cleared same edge (0-cycle latency). res_ready=1 then.
//  Not defined: all results pass through FIFO; 1-cycle minimum latency.
// STRUCTURE
//  sme_pkg additions: typedef logic [15:0] sme_pending_t;
//    parameter SME_RES_FIFO_DEPTH = 4; reuse sme_result_t unchanged.
//  Sub-module sme_result_fifo (parameterised DEPTH, sme_result_t entries,
//    valid/ready both sides, flush). Scoreboard and bypass mux in top.
// TESTING
//  1 Reset: assert g_reset mid-stream -> wb_valid=0, pending=0, res_ready=1 async.
//  2 Issue rd=3, result {0xDEADBEEF,3} cycle 5, wb_ready=1 -> wb cycle 6
//    rd=3 data 0xDEADBEEF, pending[3] 1->0 after pop.
//  3 wb_ready=0, push 4 results -> res_ready=0 after 4th; 5th held; pop one ->
//    res_ready=1, order preserved across pointer wrap (push 10 total).
//  4 pending[5]=1, issue rs2=5 -> issue_hazard=1, pending unchanged; same-cycle
//    pop of rd=5 and issue rd=5 -> pending[5] stays 1.
//  5 Result rd=7 with pending[7]=0 -> proto_err one cycle, data still written back.
//  6 flush with 3 buffered + concurrent push -> next cycle empty, pending=0;
//    with SME_RESULT_BYPASS_EN: empty FIFO, push+wb_ready same cycle -> 0-latency wb.

Source files
------------

// File: rtl/sme_pkg.sv
// rtl/sme_pkg.sv - shared SME types: result record, share-register scoreboard, FIFO depth
package sme_pkg;

    localparam int XLEN = 32;

    // Result returned by the SME to the host: {rd_wdata, rd_addr}
    typedef struct packed {
        logic [XLEN-1:0] rd_wdata;
        logic [3:0]      rd_addr;
    } sme_result_t;

    // One bit per share register; set while a result for it is outstanding
    typedef logic [15:0] sme_pending_t;

    parameter int SME_RES_FIFO_DEPTH = 4;

endpackage

// File: rtl/sme_result_fifo.sv
// rtl/sme_result_fifo.sv - result FIFO with valid/ready on both sides and a synchronous flush
module sme_result_fifo
    import sme_pkg::*;
#(
    parameter int DEPTH = SME_RES_FIFO_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  sme_result_t in_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output sme_result_t out_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    sme_result_t mem_q [DEPTH];

    logic full, empty, push, pop;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign in_ready_o  = !full;
    assign out_valid_o = !empty;
    // Head reads as zero while empty so the writeback bus is quiet when idle
    assign out_data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Flush overrides any handshake in the same cycle
    assign push = in_valid_i && !full && !flush_i;
    assign pop  = out_ready_i && !empty && !flush_i;

    // Next-state pointers
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only observed through a non-empty head
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
    end

endmodule

// File: rtl/sme_result_wb.sv
// rtl/sme_result_wb.sv - SME result receiver, writeback port and share scoreboard (option: SME_RESULT_BYPASS_EN)
module sme_result_wb
    import sme_pkg::*;
#(
    parameter int DEPTH = SME_RES_FIFO_DEPTH
) (
    input  logic                        g_clk,
    input  logic                        g_reset,
    input  logic                        flush,
    input  logic                        issue_valid,
    input  logic [3:0]                  issue_rs1_addr,
    input  logic [3:0]                  issue_rs2_addr,
    input  logic [3:0]                  issue_rd_addr,
    output logic                        issue_hazard,
    input  logic                        res_valid,
    output logic                        res_ready,
    input  logic [$bits(sme_result_t)-1:0] res_data,
    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic [3:0]                  wb_rd_addr,
    output logic [XLEN-1:0]             wb_rd_wdata,
    output sme_pending_t                pending,
    output logic                        proto_err
);

    sme_pending_t pending_q, pending_d;
    logic         proto_err_q, proto_err_d;

    sme_result_t res_in, fifo_out, wb_res;
    logic        fifo_in_valid, fifo_in_ready, fifo_out_valid;
    logic        issue_acc, res_hs, wb_hs;

    assign res_in = sme_result_t'(res_data);

    sme_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (g_clk),
        .rst_i       (g_reset),
        .flush_i     (flush),
        .in_valid_i  (fifo_in_valid),
        .in_ready_o  (fifo_in_ready),
        .in_data_i   (res_in),
        .out_valid_o (fifo_out_valid),
        .out_ready_i (wb_ready),
        .out_data_o  (fifo_out)
    );

`ifdef SME_RESULT_BYPASS_EN
    // An empty FIFO lets the incoming result straight onto the writeback port;
    // if the host takes it that cycle it is never stored
    logic bypass_sel;
    assign bypass_sel    = !fifo_out_valid && res_valid;
    assign wb_valid      = fifo_out_valid || res_valid;
    assign wb_res        = bypass_sel ? res_in : fifo_out;
    assign fifo_in_valid = res_valid && !(bypass_sel && wb_ready);
`else
    assign wb_valid      = fifo_out_valid;
    assign wb_res        = fifo_out;
    assign fifo_in_valid = res_valid;
`endif

    assign res_ready    = fifo_in_ready;
    assign wb_rd_addr   = wb_res.rd_addr;
    assign wb_rd_wdata  = wb_res.rd_wdata;
    assign pending      = pending_q;
    assign proto_err    = proto_err_q;

    assign issue_hazard = pending_q[issue_rs1_addr] | pending_q[issue_rs2_addr] | pending_q[issue_rd_addr];
    assign issue_acc    = issue_valid && !issue_hazard;
    assign res_hs       = res_valid && res_ready;
    assign wb_hs        = wb_valid && wb_ready;

    // Scoreboard update: writeback clears, accepted issue sets (set applied last so it wins)
    always_comb begin
        pending_d   = pending_q;
        proto_err_d = 1'b0;
        if (flush) begin
            pending_d = '0;
        end else begin
            if (wb_hs)     pending_d[wb_rd_addr]    = 1'b0;
            if (issue_acc) pending_d[issue_rd_addr] = 1'b1;
            proto_err_d = res_hs && !pending_q[res_in.rd_addr];
        end
    end

    // Scoreboard and protocol-error pulse registers
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            pending_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_sme_result_wb.sv
// tb/tb_sme_result_wb.sv - directed and random bench for sme_result_wb with an expected-result queue
module tb_sme_result_wb;
    import sme_pkg::*;

    localparam int DEPTH = 4;
`ifdef SME_RESULT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        g_clk, g_reset, flush;
    logic        issue_valid;
    logic [3:0]  issue_rs1_addr, issue_rs2_addr, issue_rd_addr;
    logic        issue_hazard;
    logic        res_valid, res_ready;
    logic [35:0] res_data;
    logic        wb_valid, wb_ready;
    logic [3:0]  wb_rd_addr;
    logic [31:0] wb_rd_wdata;
    logic [15:0] pending;
    logic        proto_err;

    int          n_vec = 0;
    int          n_err = 0;
    sme_result_t exp_q[$];
    logic [15:0] m_pend;
    logic        m_proto;
    bit          acc;
    int          k;

    sme_result_wb #(.DEPTH(DEPTH)) dut (
        .g_clk          (g_clk),
        .g_reset        (g_reset),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_rs1_addr (issue_rs1_addr),
        .issue_rs2_addr (issue_rs2_addr),
        .issue_rd_addr  (issue_rd_addr),
        .issue_hazard   (issue_hazard),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_rd_addr     (wb_rd_addr),
        .wb_rd_wdata    (wb_rd_wdata),
        .pending        (pending),
        .proto_err      (proto_err)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pend  = '0;
        m_proto = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model
    task automatic step();
        logic        hz, rr, wv, push, pop, byp_take;
        sme_result_t head, rin;
        @(negedge g_clk);
        rin = sme_result_t'(res_data);
        hz  = m_pend[issue_rs1_addr] | m_pend[issue_rs2_addr] | m_pend[issue_rd_addr];
        rr  = exp_q.size() < DEPTH;
        wv  = (exp_q.size() != 0) || (BYP && res_valid);
        if (exp_q.size() != 0)      head = exp_q[0];
        else if (BYP && res_valid)  head = rin;
        else                        head = '0;
        chk("issue_hazard", issue_hazard, hz);
        chk("res_ready",    res_ready,    rr);
        chk("wb_valid",     wb_valid,     wv);
        chk("wb_rd_addr",   wb_rd_addr,   head.rd_addr);
        chk("wb_rd_wdata",  wb_rd_wdata,  head.rd_wdata);
        chk("pending",      pending,      m_pend);
        chk("proto_err",    proto_err,    m_proto);
        push     = res_valid && rr;
        pop      = wv && wb_ready;
        byp_take = 1'b0;
        acc      = 1'b0;
        if (flush) begin
            model_reset();
        end else begin
            m_proto = push && !m_pend[rin.rd_addr];
            if (pop) begin
                m_pend[head.rd_addr] = 1'b0;
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                else                   byp_take = 1'b1;
            end
            if (issue_valid && !hz) m_pend[issue_rd_addr] = 1'b1;
            if (push && !byp_take) exp_q.push_back(rin);
            acc = push;
        end
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; issue_valid = 0; issue_rs1_addr = 0; issue_rs2_addr = 0; issue_rd_addr = 0;
        res_valid = 0; res_data = '0; wb_ready = 0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        g_reset = 1'b1;
        repeat (2) @(posedge g_clk);
        #1 g_reset = 1'b0;
        step();

        // Issue rd=3, its result returns, written back, scoreboard clears
        issue_valid = 1; issue_rd_addr = 4'd3; step();
        issue_valid = 0;
        chk("t2_pending3_set", pending[3], 1'b1);
        res_valid = 1; res_data = {32'hDEADBEEF, 4'd3}; wb_ready = 1; step();
        res_valid = 0; step(); step();
        chk("t2_pending3_clr", pending[3], 1'b0);

        // Fill to full with the host stalled, then drain slowly across pointer wrap
        wb_ready = 0; k = 0;
        for (int c = 0; c < 80 && k < 10; c++) begin
            res_valid = 1;
            res_data  = {32'hA5A50000 + 32'(k), 4'(k)};
            wb_ready  = (c >= 6) && c[0];
            step();
            if (acc) k++;
        end
        res_valid = 0;
        chk("t3_all_pushed", k, 10);
        wb_ready = 1; repeat (6) step();
        chk("t3_drained", wb_valid, 1'b0);

        // RAW hazard on rd=5 is refused; pop and re-issue of rd=6 in one cycle keeps it pending
        wb_ready = 0;
        issue_valid = 1; issue_rd_addr = 4'd5; step();
        issue_rs2_addr = 4'd5; issue_rd_addr = 4'd9; step();
        issue_valid = 0; issue_rs2_addr = 0;
        chk("t4_pend9_clear", pending[9], 1'b0);
        res_valid = 1; res_data = {32'h0000_0606, 4'd6}; step();
        res_valid = 0;
        wb_ready = 1; issue_valid = 1; issue_rd_addr = 4'd6; step();
        issue_valid = 0; step();
        chk("t4_pend6_setwins", pending[6], 1'b1);

        // Result for non-pending rd=7 flags proto_err but is still written back
        res_valid = 1; res_data = {32'h7777_0007, 4'd7}; step();
        res_valid = 0; step(); step();

        // Flush with three buffered results and a concurrent push and issue
        wb_ready = 0;
        issue_valid = 1; issue_rd_addr = 4'd1; step();
        issue_rd_addr = 4'd2; step();
        issue_valid = 0;
        for (int i = 0; i < 3; i++) begin
            res_valid = 1; res_data = {32'hF00D0000 + 32'(i), 4'(i + 1)}; step();
        end
        flush = 1; issue_valid = 1; issue_rd_addr = 4'd11; res_data = {32'hBAD0BAD0, 4'd4}; step();
        flush = 0; issue_valid = 0; res_valid = 0; step();
        chk("t6_flush_empty", wb_valid, 1'b0);
        chk("t6_flush_pend",  pending, 16'h0000);

        // Empty FIFO, push with host ready: same-cycle writeback when bypass is built in
        res_valid = 1; wb_ready = 1; res_data = {32'h0BAD_CAFE, 4'd12}; step();
        res_valid = 0; step(); step();

        // Asynchronous reset mid-stream
        issue_valid = 1; issue_rd_addr = 4'd8; step();
        issue_valid = 0; wb_ready = 0;
        res_valid = 1; res_data = {32'h1234_5678, 4'd8}; step(); step();
        res_valid = 0;
        #2 g_reset = 1'b1;
        #1;
        chk("rst_wb_valid",  wb_valid,  1'b0);
        chk("rst_pending",   pending,   16'h0000);
        chk("rst_res_ready", res_ready, 1'b1);
        chk("rst_wb_addr",   wb_rd_addr, 4'd0);
        model_reset();
        @(posedge g_clk);
        #1 g_reset = 1'b0;
        step();

        // Random traffic
        for (int i = 0; i < 120; i++) begin
            flush          = ($urandom_range(0, 19) == 0);
            issue_valid    = $urandom_range(0, 1);
            issue_rs1_addr = 4'($urandom_range(0, 15));
            issue_rs2_addr = 4'($urandom_range(0, 15));
            issue_rd_addr  = 4'($urandom_range(0, 15));
            res_valid      = ($urandom_range(0, 2) != 0);
            res_data       = {32'($urandom), 4'($urandom_range(0, 15))};
            wb_ready       = $urandom_range(0, 1);
            step();
        end
        idle_inputs();
        wb_ready = 1; repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
